seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexed scan controller for a bank of common-cathode seven-segment digits that share one segment bus. It holds one 4-bit hex value plus decimal point per digit, decodes the value to segment patterns, and cycles a one-hot digit select through the bank. Blanking between digits prevents ghosting. Host writes go to shadow registers and are committed only at frame boundaries, so a displayed frame never tears.

## Interface
- NUM_DIGITS, 4, number of digits in the bank (2..8)
- PRESCALE, 1000, clock cycles per digit slot (>= 4)
- BLANK_CYCLES, 16, cycles at the start of each slot with all outputs off (1 <= BLANK_CYCLES < PRESCALE)

- clk  input  1  system clock; single clock domain
- rst  input  1  asynchronous, active-high reset
- load  input  1  write strobe for one shadow digit
- load_idx  input  3  target digit index; writes with index >= NUM_DIGITS are ignored
- load_data  input  4  hex value 0x0..0xF
- load_dp  input  1  decimal point for that digit
- digit_en  input  NUM_DIGITS  per-digit enable, sampled at commit
- digit_sel  output  NUM_DIGITS  one-hot active-high digit drive, registered
- seg  output  7  active-high segments {g,f,e,d,c,b,a}, registered
- dp  output  1  active-high decimal point, registered
- frame_tick  output  1  one-cycle pulse in the last cycle of each frame, registered

## Operation
- Storage:
  - Shadow bank: value[4] plus dp[1] per digit.
  - Display bank: same contents, plus a latched copy of digit_en.
- Load: on each clock edge with load=1 and load_idx < NUM_DIGITS, the shadow entry load_idx takes {load_data, load_dp}. Loads can arrive every cycle.
- Commit: on the edge that ends the last cycle of a frame (the cycle where frame_tick=1), the display bank copies the shadow bank and digit_en as they stood before that edge.
  - A load in the same cycle updates only the shadow bank and is shown in the following frame.
- Scan state machine:
  - States: BLANK and SHOW.
  - A slot counter runs 0..PRESCALE-1. The digit index runs 0..NUM_DIGITS-1 and wraps to 0.
  - BLANK covers slot cycles 0..BLANK_CYCLES-1.
  - SHOW covers slot cycles BLANK_CYCLES..PRESCALE-1.
  - After SHOW the block returns to BLANK and advances the digit index.
- Outputs in BLANK: digit_sel=0, seg=0, dp=0.
- Outputs in SHOW for digit k:
  - If the latched digit_en[k]=1: digit_sel has only bit k set, seg is the decode of value[k], and dp is dp[k].
  - If the latched digit_en[k]=0: all outputs are 0. The slot is still consumed, so frame timing does not change.
- Decode, seg values as hex:
  - 0→3F, 1→06, 2→5B, 3→4F
  - 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C
  - C→39, d→5E, E→79, F→71
- Counter widths: use the smallest width that holds PRESCALE-1 and NUM_DIGITS-1. No overflow may occur at the maximum parameter values.

## Timing
- Reset (asynchronous assert) immediately forces:
  - digit_sel=0, seg=0, dp=0, frame_tick=0
  - slot counter=0, digit index=0, state BLANK
  - shadow and display banks = 0, latched digit_en = 0 (all digits off)
- Frame numbering: cycle 0 is the first rising edge after rst deasserts. Digit k occupies frame cycles k·PRESCALE .. (k+1)·PRESCALE−1. Frame length is NUM_DIGITS·PRESCALE.
- Output placement: outputs are registered, but the RTL must precompute next-state values so that outputs hold their specified values exactly in the listed cycles. There is no extra lag.
- digit_sel[k] is high for exactly PRESCALE−BLANK_CYCLES consecutive cycles per frame.
- Two bits of digit_sel are never high in the same cycle.
- frame_tick is high in frame cycle NUM_DIGITS·PRESCALE−1 only.
- Because the latched digit_en resets to 0, the first frame after reset is dark. Data loaded before the first commit appears starting in frame 1.
- Reset mid-frame: all outputs go to 0 asynchronously. Scanning restarts at digit 0 and the display is dark until the next commit.
- Inputs load, load_idx, load_data, load_dp and digit_en are synchronous to clk. There is no backpressure.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.

- **Reset values:** assert rst mid-SHOW → all outputs 0 in the same cycle; after release, frame_tick first pulses at cycle 31.
- **Basic scan:** load digits 0..3 = 1,2,3,4 with dp only on digit 2, digit_en=4'hF, all before cycle 31.
  - Frame 1: sel 0001/seg 06 at cycles 34–39, sel 0010/seg 5B at 42–47, sel 0100/seg 4F/dp=1 at 50–55, sel 1000/seg 66 at 58–63.
  - Cycles 32–33, 40–41, 48–49 and 56–57: all outputs 0.
- **Tearing:** write digit 0 = 8 at cycle 40, mid-frame 1 → digit 0 still shows 06 until frame 2, then shows 7F at cycles 66–71.
- **Commit collision:** load digit 1 = F in the frame_tick cycle (cycle 63) → frame 2 shows the old value; frame 3 shows seg 71 at cycles 106–111.
- **Enable mask:** digit_en=4'b0101 at commit → slots 1 and 3 stay fully dark while slot timing is unchanged; slots 0 and 2 keep their normal windows.
- **Decode sweep and bad index:** cycle values 0x0–0xF through digit 0 and check all 16 seg codes. A load with load_idx=5 must leave every digit unchanged.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: shadow/display double-buffered digits,
// one-hot digit scan with a blanking window at the start of every slot.

module seven_seg_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [3:0] wr_val,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic       en,
  output logic [3:0] disp_val,
  output logic       disp_dp,
  output logic       disp_en
);
  logic [3:0] shadow_val;
  logic       shadow_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= 1'b0;
    end else if (wr) begin
      shadow_val <= wr_val;
      shadow_dp  <= wr_dp;
    end
  end

  // Commit reads the shadow as it stood before this edge, so a same-cycle
  // write lands in the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val <= '0;
      disp_dp  <= 1'b0;
      disp_en  <= 1'b0;
    end else if (commit) begin
      disp_val <= shadow_val;
      disp_dp  <= shadow_dp;
      disp_en  <= en;
    end
  end
endmodule

module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [2:0]            load_idx,
  input  logic [3:0]            load_data,
  input  logic                  load_dp,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int unsigned SLOT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

  typedef enum logic {BLANK, SHOW} state_t;

  // slot/idx/state describe the cycle about to start, so the registered
  // outputs land in exactly the cycle they belong to.
  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              last_slot, last_digit;

  logic [NUM_DIGITS-1:0][3:0] disp_val;
  logic [NUM_DIGITS-1:0]      disp_dp;
  logic [NUM_DIGITS-1:0]      disp_en;

  logic [NUM_DIGITS-1:0] sel_d;
  logic [6:0]            seg_d;
  logic                  dp_d, tick_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seven_seg_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .wr       (load && (load_idx == 3'(k))),
      .wr_val   (load_data),
      .wr_dp    (load_dp),
      .commit   (frame_tick),
      .en       (digit_en[k]),
      .disp_val (disp_val[k]),
      .disp_dp  (disp_dp[k]),
      .disp_en  (disp_en[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      slot  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    last_slot  = (slot == SLOT_W'(PRESCALE - 1));
    last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    slot_nxt   = last_slot ? '0 : slot + 1'b1;
    idx_nxt    = idx;
    if (last_slot) idx_nxt = last_digit ? '0 : idx + 1'b1;
    state_nxt  = state;
    case (state)
      BLANK:   if (slot == SLOT_W'(BLANK_CYCLES - 1)) state_nxt = SHOW;
      SHOW:    if (last_slot) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    sel_d  = '0;
    seg_d  = '0;
    dp_d   = 1'b0;
    tick_d = last_slot && last_digit;
    // A disabled digit still consumes its slot; it is simply dark.
    if (state == SHOW && disp_en[idx]) begin
      sel_d = NUM_DIGITS'(1) << idx;
      seg_d = decode(disp_val[idx]);
      dp_d  = disp_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel  <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      digit_sel  <= sel_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= tick_d;
    end
  end
endmodule
